branch_resolve: RTL and testbench

- EX-stage branch/jump resolution unit that sits directly downstream of the branch comparator.
- Drives the comparator's BranchOp select from funct3, and consumes its BrEq/BrLT flags.
- Decides taken/not-taken, computes the target, and detects mispredicts against the fetch prediction.
- On a mispredict, issues a registered PC redirect plus a multi-cycle pipeline flush sequence, and keeps resolution statistics.

---
 rtl/branch_resolve.sv | 104 ++++++++++
 tb/tb_branch_resolve.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch/jump resolution, mispredict redirect and flush sequencing
module branch_resolve #(
    parameter int DATA_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic                   i_stall,
    input  logic                   i_is_branch,
    input  logic                   i_is_jal,
    input  logic                   i_is_jalr,
    input  logic [2:0]             i_funct3,
    input  logic                   i_pred_taken,
    input  logic                   i_BrEq,
    input  logic                   i_BrLT,
    input  logic [DATA_WIDTH-1:0]  i_pc,
    input  logic [DATA_WIDTH-1:0]  i_imm,
    input  logic [DATA_WIDTH-1:0]  i_rs1,
    output logic                   o_BranchOp,
    output logic                   o_redirect,
    output logic [DATA_WIDTH-1:0]  o_target,
    output logic                   o_flush,
    output logic                   o_busy,
    output logic                   o_misaligned,
    output logic [COUNT_WIDTH-1:0] o_br_count,
    output logic [COUNT_WIDTH-1:0] o_mispred_count
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  legal, cond, taken, resolve, misal, go, br_inc;
    logic [DATA_WIDTH-1:0] jalr_sum, taken_tgt, redir_tgt;

    // funct3 bit0 inverts the comparison; bit2 selects less-than over equality
    always_comb begin
        o_BranchOp = (i_funct3 == 3'b100) || (i_funct3 == 3'b101);
        legal      = i_funct3[2:1] != 2'b01;
        cond       = i_funct3[2] ? (i_BrLT ^ i_funct3[0]) : (i_BrEq ^ i_funct3[0]);
        taken      = i_is_jal || i_is_jalr || (legal && cond);
        jalr_sum   = i_rs1 + i_imm;
        taken_tgt  = (!i_is_jal && i_is_jalr) ? {jalr_sum[DATA_WIDTH-1:1], 1'b0} : i_pc + i_imm;
        redir_tgt  = taken ? taken_tgt : i_pc + DATA_WIDTH'(4);
        resolve    = (state == IDLE) && i_valid && !i_stall && (i_is_branch || i_is_jal || i_is_jalr);
        misal      = taken && (taken_tgt[1:0] != 2'b00);
        go         = resolve && !misal && (taken != i_pred_taken);
        br_inc     = resolve && i_is_branch && !i_is_jal && !i_is_jalr && legal;
    end

    // next-state: one redirect cycle, then FLUSH_CYCLES-1 counted flush cycles
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE:     state_nxt = go ? REDIRECT : IDLE;
            REDIRECT: begin
                cnt_nxt   = CW'(FLUSH_CYCLES - 2);
                state_nxt = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
            end
            FLUSH:    begin
                cnt_nxt   = cnt - CW'(1);
                state_nxt = (cnt == 0) ? IDLE : FLUSH;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // registered redirect target, misaligned strobe and saturating statistics
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_target        <= '0;
            o_misaligned    <= 1'b0;
            o_br_count      <= '0;
            o_mispred_count <= '0;
        end else begin
            o_misaligned <= resolve && misal;
            if (go)
                o_target <= redir_tgt;
            if (br_inc && !(&o_br_count))
                o_br_count <= o_br_count + COUNT_WIDTH'(1);
            if (go && !(&o_mispred_count))
                o_mispred_count <= o_mispred_count + COUNT_WIDTH'(1);
        end
    end

    assign o_redirect = state == REDIRECT;
    assign o_flush    = state != IDLE;
    assign o_busy     = state != IDLE;
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: random and directed checks of two branch_resolve configurations against a reference model
module tb_branch_resolve;
    logic        clk = 1'b0, rst = 1'b1;
    logic        valid, stall, is_br, is_jal, is_jalr, pred, br_eq, br_lt;
    logic [2:0]  f3;
    logic [31:0] pc, imm, rs1;
    logic        op_a, redir_a, flush_a, busy_a, mis_a;
    logic        op_b, redir_b, flush_b, busy_b, mis_b;
    logic [31:0] tgt_a, tgt_b;
    logic [15:0] brc_a, mpc_a;
    logic [3:0]  brc_b, mpc_b;
    int          checks = 0, failures = 0;
    int          left[2], brn[2], mpn[2];
    logic [31:0] mtgt[2];
    bit          mmis[2];
    int          fc[2]   = '{2, 3};
    int          cmax[2] = '{65535, 15};

    branch_resolve dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall), .i_is_branch(is_br),
        .i_is_jal(is_jal), .i_is_jalr(is_jalr), .i_funct3(f3), .i_pred_taken(pred),
        .i_BrEq(br_eq), .i_BrLT(br_lt), .i_pc(pc), .i_imm(imm), .i_rs1(rs1),
        .o_BranchOp(op_a), .o_redirect(redir_a), .o_target(tgt_a), .o_flush(flush_a),
        .o_busy(busy_a), .o_misaligned(mis_a), .o_br_count(brc_a), .o_mispred_count(mpc_a)
    );

    branch_resolve #(.DATA_WIDTH(32), .FLUSH_CYCLES(3), .COUNT_WIDTH(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall), .i_is_branch(is_br),
        .i_is_jal(is_jal), .i_is_jalr(is_jalr), .i_funct3(f3), .i_pred_taken(pred),
        .i_BrEq(br_eq), .i_BrLT(br_lt), .i_pc(pc), .i_imm(imm), .i_rs1(rs1),
        .o_BranchOp(op_b), .o_redirect(redir_b), .o_target(tgt_b), .o_flush(flush_b),
        .o_busy(busy_b), .o_misaligned(mis_b), .o_br_count(brc_b), .o_mispred_count(mpc_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_taken(input logic [2:0] f, input bit eq, input bit lt);
        case (f)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            left[k] = 0; brn[k] = 0; mpn[k] = 0; mtgt[k] = 0; mmis[k] = 0;
        end
    endtask

    task automatic drive(input bit v, input bit s, input bit b, input bit j, input bit jr,
                         input logic [2:0] f, input bit p, input bit eq, input bit lt,
                         input logic [31:0] pc_v, input logic [31:0] imm_v, input logic [31:0] rs1_v);
        valid = v; stall = s; is_br = b; is_jal = j; is_jalr = jr; f3 = f; pred = p;
        br_eq = eq; br_lt = lt; pc = pc_v; imm = imm_v; rs1 = rs1_v;
        #1;
        check("branchop_a", op_a, (f == 3'd4 || f == 3'd5));
        check("branchop_b", op_b, (f == 3'd4 || f == 3'd5));
    endtask

    task automatic check_outputs();
        check("redirect_a", redir_a, left[0] == fc[0]);
        check("flush_a",    flush_a, left[0] > 0);
        check("busy_a",     busy_a,  left[0] > 0);
        check("misal_a",    mis_a,   mmis[0]);
        check("target_a",   tgt_a,   mtgt[0]);
        check("brcount_a",  brc_a,   brn[0]);
        check("mpcount_a",  mpc_a,   mpn[0]);
        check("redirect_b", redir_b, left[1] == fc[1]);
        check("flush_b",    flush_b, left[1] > 0);
        check("busy_b",     busy_b,  left[1] > 0);
        check("misal_b",    mis_b,   mmis[1]);
        check("target_b",   tgt_b,   mtgt[1]);
        check("brcount_b",  brc_b,   brn[1]);
        check("mpcount_b",  mpc_b,   mpn[1]);
    endtask

    // predict the effect of the coming edge, let it happen, then compare mid-cycle
    task automatic tick();
        bit          t;
        logic [31:0] tt;
        for (int k = 0; k < 2; k++) begin
            mmis[k] = 0;
            if (left[k] > 0)
                left[k]--;
            else if (valid && !stall && (is_br || is_jal || is_jalr)) begin
                if (is_jal) begin
                    t = 1; tt = pc + imm;
                end else if (is_jalr) begin
                    t = 1; tt = (rs1 + imm) & ~32'd1;
                end else begin
                    t = ref_taken(f3, br_eq, br_lt); tt = pc + imm;
                    if (f3 != 3'd2 && f3 != 3'd3 && brn[k] < cmax[k]) brn[k]++;
                end
                if (t && tt[1:0] != 2'b00)
                    mmis[k] = 1;
                else if (t != pred) begin
                    left[k] = fc[k];
                    mtgt[k] = t ? tt : pc + 32'd4;
                    if (mpn[k] < cmax[k]) mpn[k]++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        // BEQ taken, predicted not taken
        drive(1, 0, 1, 0, 0, 3'd0, 0, 1, 0, 32'h100, 32'h20, 32'h0);
        tick();
        check("t1_target", tgt_a, 32'h120);
        check("t1_redirect", redir_a, 1'b1);
        idle(4);
        // BLT correctly predicted taken, BLTU select
        drive(1, 0, 1, 0, 0, 3'd4, 1, 0, 1, 32'h140, 32'h40, 32'h0);
        tick();
        check("t2_noflush", flush_a, 1'b0);
        drive(1, 0, 1, 0, 0, 3'd6, 0, 0, 0, 32'h150, 32'h40, 32'h0);
        tick();
        // BNE not taken but predicted taken
        drive(1, 0, 1, 0, 0, 3'd1, 1, 1, 0, 32'h200, 32'h40, 32'h0);
        tick();
        check("t3_bne_target", tgt_a, 32'h204);
        idle(3);
        // JALR clears bit 0
        drive(1, 0, 0, 0, 1, 3'd0, 0, 0, 0, 32'h400, 32'h4, 32'h301);
        tick();
        check("t3_jalr_target", tgt_a, 32'h304);
        idle(3);
        // JAL to a misaligned target, then an illegal funct3
        drive(1, 0, 0, 1, 0, 3'd0, 0, 0, 0, 32'h10, 32'h6, 32'h0);
        tick();
        check("t4_misal", mis_a, 1'b1);
        check("t4_busy", busy_a, 1'b0);
        drive(1, 0, 1, 0, 0, 3'd2, 1, 1, 1, 32'h20, 32'h8, 32'h0);
        tick();
        // stalled mispredict resolves only after stall drops
        drive(1, 1, 1, 0, 0, 3'd0, 0, 1, 0, 32'h500, 32'h10, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        check("t5_stall_busy", busy_a, 1'b0);
        drive(1, 0, 1, 0, 0, 3'd0, 0, 1, 0, 32'h500, 32'h10, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        check("t5_flush_b_end", flush_b, 1'b0);
        idle(4);
        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r_pc, r_imm, r_rs1;
            r_pc = $urandom & ~32'd3;
            r_imm = $urandom;
            r_rs1 = $urandom;
            if ($urandom_range(3) != 0) r_imm[1:0] = 2'b00;
            if ($urandom_range(3) != 0) r_rs1[1:0] = 2'(r_imm[1:0] == 0 ? $urandom_range(1) : 0);
            drive($urandom_range(4) != 0, $urandom_range(4) == 0, $urandom_range(1), $urandom_range(5) == 0,
                  $urandom_range(5) == 0, 3'($urandom_range(7)), $urandom_range(1), $urandom_range(1),
                  $urandom_range(1), r_pc, r_imm, r_rs1);
            tick();
        end
        idle(4);
        // saturation: 20 correctly predicted taken BEQs
        drive(1, 0, 1, 0, 0, 3'd0, 1, 1, 0, 32'h600, 32'h8, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        check("t6_sat_b", brc_b, 4'hF);
        // reset mid-flush
        drive(1, 0, 1, 0, 0, 3'd0, 0, 1, 0, 32'h700, 32'h20, 32'h0);
        tick();
        idle(1);
        #2 rst = 1'b1;
        #1 model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 1, 0, 0, 3'd0, 0, 1, 0, 32'h100, 32'h20, 32'h0);
        tick();
        check("t6_post_rst_redirect", redir_a, 1'b1);
        check("t6_post_rst_target", tgt_a, 32'h120);
        idle(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
